// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad FIFO block: register map, bit fields,
// scanner states and the PmodKYPD keymap.
package keypad_pkg;

    localparam logic [3:0] ADDR_KEY    = 4'h3;
    localparam logic [3:0] ADDR_STATUS = 4'h4;
    localparam logic [3:0] ADDR_CTRL   = 4'h5;

    localparam int unsigned ST_NONEMPTY  = 0;
    localparam int unsigned ST_OVF       = 1;
    localparam int unsigned ST_HELD      = 2;
    localparam int unsigned ST_COUNT_LSB = 4;

    localparam int unsigned CTRL_IEN   = 0;
    localparam int unsigned CTRL_FLUSH = 1;

    typedef enum logic [1:0] {
        ScCol0 = 2'd0,
        ScCol1 = 2'd1,
        ScCol2 = 2'd2,
        ScCol3 = 2'd3
    } scan_state_e;

    function automatic logic [3:0] key_code(input logic [1:0] row_idx,
                                            input logic [1:0] col_idx);
        logic [3:0] code;
        code = 4'h0;
        case ({row_idx, col_idx})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'h0;
            4'b11_01: code = 4'hF;
            4'b11_10: code = 4'hE;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_fifo_io_sync_fifo.sv
// Synchronous FIFO with flush; a push into a full FIFO succeeds when a pop
// happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int unsigned AddrW  = $clog2(DEPTH);
    localparam int unsigned CountW = AddrW + 1;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [AddrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CountW-1:0] count_q, count_d;
    logic              wr_en, rd_en;

    assign full  = (count_q == CountW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    assign wr_en = push && !flush && (!full || pop);
    assign rd_en = pop && !flush && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + AddrW'(1);
            if (rd_en) rd_ptr_d = rd_ptr_q + AddrW'(1);
            case ({wr_en, rd_en})
                2'b10:   count_d = count_q + CountW'(1);
                2'b01:   count_d = count_q - CountW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/keypad_fifo_io.sv
// 4x4 keypad scanner with frame debounce, key-event FIFO and a small
// KEY/STATUS/CTRL register interface with level interrupt.
module keypad_fifo_io
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_CYCLES     = 100000,
    parameter int unsigned DEBOUNCE_FRAMES = 4,
    parameter int unsigned FIFO_DEPTH      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] addr,
    input  logic [7:0] data_in,
    input  logic       we,
    input  logic       re,
    output logic [7:0] data_out,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic       irq
);
    localparam int unsigned DwellW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int unsigned FrameW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam int unsigned CountW = $clog2(FIFO_DEPTH) + 1;

    logic [3:0]        row_meta_q, row_sync_q;
    scan_state_e       state_q, state_d;
    logic [DwellW-1:0] dwell_q, dwell_d;
    logic              dwell_last, frame_end;
    logic              hit_q, hit_d, prev_hit_q, prev_hit_d, acc_hit_q, acc_hit_d;
    logic [3:0]        code_q, code_d, prev_code_q, prev_code_d, acc_code_q, acc_code_d;
    logic [FrameW-1:0] cnt_q, cnt_d;
    logic [1:0]        row_idx;
    logic              row_hit, res_hit, same, push;
    logic [3:0]        res_code;
    logic              ien_q, ien_d, ovf_q, ovf_d, irq_q, rd_key_q;
    logic              rd_key, pop, ctrl_wr, flush;
    logic [3:0]        fifo_dout, count_sat;
    logic [CountW-1:0] fifo_count;
    logic              fifo_full, fifo_empty;
    logic              unused_data;

    assign unused_data = ^data_in[7:2];

    assign dwell_last = (dwell_q == DwellW'(SCAN_CYCLES - 1));
    assign frame_end  = dwell_last && (state_q == ScCol3);

    always_comb begin
        state_d = state_q;
        dwell_d = dwell_q + DwellW'(1);
        col     = 4'b1110;
        unique case (state_q)
            ScCol0: col = 4'b1110;
            ScCol1: col = 4'b1101;
            ScCol2: col = 4'b1011;
            ScCol3: col = 4'b0111;
        endcase
        if (dwell_last) begin
            dwell_d = '0;
            unique case (state_q)
                ScCol0: state_d = ScCol1;
                ScCol1: state_d = ScCol2;
                ScCol2: state_d = ScCol3;
                ScCol3: state_d = ScCol0;
            endcase
        end
    end

    // The frame result is built up column by column; the first hit wins.
    always_comb begin
        row_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!row_sync_q[i]) row_idx = 2'(i);
        end
        row_hit  = (row_sync_q != 4'hF);
        res_hit  = hit_q | row_hit;
        res_code = hit_q ? code_q : (row_hit ? key_code(row_idx, state_q) : 4'h0);
        same     = (res_hit == prev_hit_q) && (res_code == prev_code_q);

        hit_d       = hit_q;
        code_d      = code_q;
        prev_hit_d  = prev_hit_q;
        prev_code_d = prev_code_q;
        cnt_d       = cnt_q;
        acc_hit_d   = acc_hit_q;
        acc_code_d  = acc_code_q;
        push        = 1'b0;
        if (dwell_last) begin
            hit_d  = res_hit;
            code_d = res_code;
        end
        if (frame_end) begin
            hit_d       = 1'b0;
            code_d      = 4'h0;
            prev_hit_d  = res_hit;
            prev_code_d = res_code;
            if (!same) cnt_d = FrameW'(1);
            else if (cnt_q != FrameW'(DEBOUNCE_FRAMES)) cnt_d = cnt_q + FrameW'(1);
            if (cnt_d == FrameW'(DEBOUNCE_FRAMES)) begin
                acc_hit_d  = res_hit;
                acc_code_d = res_code;
                push       = res_hit && (!acc_hit_q || (acc_code_q != res_code));
            end
        end
    end

    assign rd_key  = re && (addr == ADDR_KEY);
    assign pop     = rd_key && !rd_key_q && !fifo_empty;
    assign ctrl_wr = we && (addr == ADDR_CTRL);
    assign flush   = ctrl_wr && data_in[CTRL_FLUSH];

    // A flush write leaves the interrupt enable untouched.
    always_comb begin
        ien_d = ien_q;
        if (ctrl_wr && !data_in[CTRL_FLUSH]) ien_d = data_in[CTRL_IEN];
        ovf_d = ovf_q;
        if (flush) ovf_d = 1'b0;
        else if (push && fifo_full && !pop) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_meta_q  <= 4'hF;
            row_sync_q  <= 4'hF;
            state_q     <= ScCol0;
            dwell_q     <= '0;
            hit_q       <= 1'b0;
            code_q      <= 4'h0;
            prev_hit_q  <= 1'b0;
            prev_code_q <= 4'h0;
            cnt_q       <= '0;
            acc_hit_q   <= 1'b0;
            acc_code_q  <= 4'h0;
            ien_q       <= 1'b0;
            ovf_q       <= 1'b0;
            irq_q       <= 1'b0;
            rd_key_q    <= 1'b0;
        end else begin
            row_meta_q  <= row;
            row_sync_q  <= row_meta_q;
            state_q     <= state_d;
            dwell_q     <= dwell_d;
            hit_q       <= hit_d;
            code_q      <= code_d;
            prev_hit_q  <= prev_hit_d;
            prev_code_q <= prev_code_d;
            cnt_q       <= cnt_d;
            acc_hit_q   <= acc_hit_d;
            acc_code_q  <= acc_code_d;
            ien_q       <= ien_d;
            ovf_q       <= ovf_d;
            irq_q       <= !fifo_empty && ien_q;
            rd_key_q    <= rd_key;
        end
    end

    sync_fifo #(
        .WIDTH (4),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (acc_code_d),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign irq = irq_q;

    always_comb begin
        count_sat = (32'(fifo_count) > 32'd15) ? 4'hF : 4'(fifo_count);
        data_out  = 8'h00;
        if (re) begin
            case (addr)
                ADDR_KEY:    data_out = fifo_empty ? 8'h00 : {1'b1, 3'b000, fifo_dout};
                ADDR_STATUS: data_out = {count_sat, 1'b0, acc_hit_q, ovf_q, !fifo_empty};
                ADDR_CTRL:   data_out = {7'b0, ien_q};
                default:     data_out = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_fifo_io.sv
// Randomized self-checking bench for keypad_fifo_io against a queue-based
// model of the key-event stream.
module tb_keypad_fifo_io;
    localparam int unsigned SCAN  = 4;
    localparam int unsigned DEB   = 2;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned FRAME = 4 * SCAN;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] addr = 4'h0;
    logic [7:0] data_in = 8'h00;
    logic       we = 1'b0;
    logic       re = 1'b0;
    logic [7:0] data_out;
    logic [3:0] row;
    logic [3:0] col;
    logic       irq;

    logic [15:0] key_mask = 16'h0000;
    logic [3:0]  keytab [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                                 4'h7, 4'h8, 4'h9, 4'hC, 4'h0, 4'hF, 4'hE, 4'hD};
    logic [3:0]  exp_q [$];
    bit          exp_ovf = 1'b0;
    bit          exp_held = 1'b0;
    int          checks = 0;
    int          failures = 0;

    keypad_fifo_io #(
        .SCAN_CYCLES     (SCAN),
        .DEBOUNCE_FRAMES (DEB),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .data_in  (data_in),
        .we       (we),
        .re       (re),
        .data_out (data_out),
        .row      (row),
        .col      (col),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    // Pressed key at (r, c) pulls row r low while column c is driven low.
    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++) begin
            if (!col[c]) begin
                for (int r = 0; r < 4; r++) begin
                    if (key_mask[r*4+c]) row[r] = 1'b0;
                end
            end
        end
    end

    function automatic void model_push(input logic [3:0] code);
        if (exp_q.size() < DEPTH) exp_q.push_back(code);
        else exp_ovf = 1'b1;
    endfunction

    function automatic logic [7:0] model_key_pop();
        logic [3:0] c;
        if (exp_q.size() == 0) return 8'h00;
        c = exp_q.pop_front();
        return {4'h8, c};
    endfunction

    function automatic logic [7:0] model_status();
        int n;
        n = exp_q.size();
        return {(n > 15) ? 4'hF : 4'(n), 1'b0, exp_held, exp_ovf, (n != 0)};
    endfunction

    task automatic wait_frames(input int n);
        repeat (n * FRAME) @(negedge clk);
    endtask

    task automatic press(input int k);
        @(negedge clk);
        key_mask = '0;
        key_mask[k] = 1'b1;
        wait_frames(5);
        model_push(keytab[k]);
        exp_held = 1'b1;
    endtask

    task automatic release_keys();
        @(negedge clk);
        key_mask = '0;
        wait_frames(5);
        exp_held = 1'b0;
    endtask

    task automatic read_reg(input logic [3:0] a, output logic [7:0] d);
        @(negedge clk);
        addr = a;
        re = 1'b1;
        #1 d = data_out;
        @(negedge clk);
        re = 1'b0;
    endtask

    task automatic write_ctrl(input logic [7:0] v);
        @(negedge clk);
        addr = 4'h5;
        data_in = v;
        we = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] got;
        repeat (3) @(negedge clk);
        checks++;
        if (col !== 4'b1110) begin
            failures++; $display("FAIL reset_col got=%b exp=1110", col);
        end
        checks++;
        if (irq !== 1'b0) begin
            failures++; $display("FAIL reset_irq got=%b exp=0", irq);
        end
        checks++;
        if (data_out !== 8'h00) begin
            failures++; $display("FAIL reset_dout got=%h exp=00", data_out);
        end
        reset = 1'b0;
        read_reg(4'h4, got);
        checks++;
        if (got !== 8'h00) begin
            failures++; $display("FAIL reset_status got=%h exp=00", got);
        end
        read_reg(4'h5, got);
        checks++;
        if (got !== 8'h00) begin
            failures++; $display("FAIL reset_ctrl got=%h exp=00", got);
        end
        read_reg(4'h3, got);
        checks++;
        if (got !== 8'h00) begin
            failures++; $display("FAIL reset_key got=%h exp=00", got);
        end
    endtask

    task automatic test_single_press();
        logic [7:0] got, exp;
        press(1 * 4 + 2);
        read_reg(4'h4, got);
        exp = model_status();
        checks++;
        if (got !== exp) begin
            failures++; $display("FAIL single_status_held got=%h exp=%h", got, exp);
        end
        wait_frames(8);
        read_reg(4'h4, got);
        checks++;
        if (got !== exp) begin
            failures++; $display("FAIL single_one_push got=%h exp=%h", got, exp);
        end
        release_keys();
        read_reg(4'h4, got);
        exp = model_status();
        checks++;
        if (got !== exp) begin
            failures++; $display("FAIL single_status_rel got=%h exp=%h", got, exp);
        end
        read_reg(4'h3, got);
        exp = model_key_pop();
        checks++;
        if (got !== exp || got !== 8'h86) begin
            failures++; $display("FAIL single_key got=%h exp=%h", got, exp);
        end
        read_reg(4'h3, got);
        exp = model_key_pop();
        checks++;
        if (got !== exp) begin
            failures++; $display("FAIL single_key_empty got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_bounce();
        logic [7:0] got, exp;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            key_mask = (i % 2 == 1) ? 16'h0001 : 16'h0000;
            repeat (FRAME - 1) @(negedge clk);
        end
        read_reg(4'h4, got);
        exp = model_status();
        checks++;
        if (got !== exp) begin
            failures++; $display("FAIL bounce_no_push got=%h exp=%h", got, exp);
        end
        press(0);
        release_keys();
        read_reg(4'h3, got);
        exp = model_key_pop();
        checks++;
        if (got !== exp || got !== 8'h81) begin
            failures++; $display("FAIL bounce_key got=%h exp=%h", got, exp);
        end
        read_reg(4'h3, got);
        checks++;
        if (got !== 8'h00) begin
            failures++; $display("FAIL bounce_single got=%h exp=00", got);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] got, exp;
        int idx [16];
        for (int i = 0; i < 16; i++) idx[i] = i;
        for (int i = 15; i > 0; i--) begin
            int j;
            int t;
            j = int'($urandom_range(i, 0));
            t = idx[i]; idx[i] = idx[j]; idx[j] = t;
        end
        for (int i = 0; i < 10; i++) begin
            press(idx[i]);
            release_keys();
        end
        read_reg(4'h4, got);
        exp = model_status();
        checks++;
        if (got !== exp || got[7:4] !== 4'd8 || got[1] !== 1'b1) begin
            failures++; $display("FAIL ovf_status got=%h exp=%h", got, exp);
        end
        for (int i = 0; i < 9; i++) begin
            read_reg(4'h3, got);
            exp = model_key_pop();
            checks++;
            if (got !== exp) begin
                failures++; $display("FAIL ovf_key%0d got=%h exp=%h", i, got, exp);
            end
        end
        read_reg(4'h4, got);
        exp = model_status();
        checks++;
        if (got !== exp) begin
            failures++; $display("FAIL ovf_sticky got=%h exp=%h", got, exp);
        end
        write_ctrl(8'h02);
        exp_q.delete();
        exp_ovf = 1'b0;
        read_reg(4'h4, got);
        exp = model_status();
        checks++;
        if (got !== exp) begin
            failures++; $display("FAIL ovf_flush got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_read_edge();
        logic [7:0] got, exp;
        int a, b;
        a = int'($urandom_range(15, 0));
        b = (a + int'($urandom_range(15, 1))) % 16;
        press(a); release_keys();
        press(b); release_keys();
        @(negedge clk);
        addr = 4'h3;
        re = 1'b1;
        #1 got = data_out;
        exp = model_key_pop();
        checks++;
        if (got !== exp) begin
            failures++; $display("FAIL edge_first got=%h exp=%h", got, exp);
        end
        @(negedge clk);
        #1 got = data_out;
        exp = {4'h8, exp_q[0]};
        checks++;
        if (got !== exp) begin
            failures++; $display("FAIL edge_head got=%h exp=%h", got, exp);
        end
        repeat (3) @(negedge clk);
        re = 1'b0;
        read_reg(4'h4, got);
        exp = model_status();
        checks++;
        if (got !== exp) begin
            failures++; $display("FAIL edge_count got=%h exp=%h", got, exp);
        end
        read_reg(4'h3, got);
        exp = model_key_pop();
        checks++;
        if (got !== exp) begin
            failures++; $display("FAIL edge_second got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_random();
        logic [7:0] got, exp;
        for (int i = 0; i < 6; i++) begin
            press(int'($urandom_range(15, 0)));
            release_keys();
            if ($urandom_range(1, 0) == 1) begin
                read_reg(4'h3, got);
                exp = model_key_pop();
                checks++;
                if (got !== exp) begin
                    failures++; $display("FAIL rand_key%0d got=%h exp=%h", i, got, exp);
                end
            end
        end
        read_reg(4'h4, got);
        exp = model_status();
        checks++;
        if (got !== exp) begin
            failures++; $display("FAIL rand_status got=%h exp=%h", got, exp);
        end
        while (exp_q.size() != 0) begin
            read_reg(4'h3, got);
            exp = model_key_pop();
            checks++;
            if (got !== exp) begin
                failures++; $display("FAIL rand_drain got=%h exp=%h", got, exp);
            end
        end
    endtask

    task automatic test_irq_flush();
        logic [7:0] got, exp;
        int  k;
        bit  seen;
        write_ctrl(8'h01);
        read_reg(4'h5, got);
        checks++;
        if (got !== 8'h01) begin
            failures++; $display("FAIL irq_ien got=%h exp=01", got);
        end
        k = int'($urandom_range(15, 0));
        @(negedge clk);
        key_mask = '0;
        key_mask[k] = 1'b1;
        addr = 4'h4;
        re = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (data_out[0]) begin
                seen = 1'b1;
                checks++;
                if (irq !== 1'b0) begin
                    failures++; $display("FAIL irq_early got=%b exp=0", irq);
                end
                @(negedge clk);
                #1;
                checks++;
                if (irq !== 1'b1) begin
                    failures++; $display("FAIL irq_rise got=%b exp=1", irq);
                end
            end
        end
        checks++;
        if (!seen) begin
            failures++; $display("FAIL irq_timeout got=empty exp=nonempty");
        end
        re = 1'b0;
        model_push(keytab[k]);
        exp_held = 1'b1;
        write_ctrl(8'h02);
        exp_q.delete();
        exp_ovf = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (irq !== 1'b0) begin
            failures++; $display("FAIL irq_flush got=%b exp=0", irq);
        end
        read_reg(4'h4, got);
        exp = model_status();
        checks++;
        if (got !== exp) begin
            failures++; $display("FAIL flush_status got=%h exp=%h", got, exp);
        end
        read_reg(4'h5, got);
        checks++;
        if (got !== 8'h01) begin
            failures++; $display("FAIL flush_ien got=%h exp=01", got);
        end
        release_keys();
        read_reg(4'h4, got);
        exp = model_status();
        checks++;
        if (got !== exp) begin
            failures++; $display("FAIL flush_release got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] got;
        bit found;
        press(int'($urandom_range(15, 0)));
        @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin
            failures++; $display("FAIL mid_irq_pre got=%b exp=1", irq);
        end
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (col === 4'b1011) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++; $display("FAIL mid_col2_timeout got=%b exp=1011", col);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (col !== 4'b1110) begin
            failures++; $display("FAIL mid_col got=%b exp=1110", col);
        end
        checks++;
        if (irq !== 1'b0) begin
            failures++; $display("FAIL mid_irq got=%b exp=0", irq);
        end
        addr = 4'h4;
        re = 1'b1;
        #1;
        checks++;
        if (data_out !== 8'h00) begin
            failures++; $display("FAIL mid_status got=%h exp=00", data_out);
        end
        addr = 4'h5;
        #1;
        checks++;
        if (data_out !== 8'h00) begin
            failures++; $display("FAIL mid_ctrl got=%h exp=00", data_out);
        end
        @(negedge clk);
        re = 1'b0;
        key_mask = '0;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        exp_ovf = 1'b0;
        exp_held = 1'b0;
        wait_frames(2);
        read_reg(4'h4, got);
        checks++;
        if (got !== model_status()) begin
            failures++; $display("FAIL mid_after got=%h exp=%h", got, model_status());
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_overflow();
        test_read_edge();
        test_random();
        test_irq_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
